// File: rtl/wb_retire_pkg.sv
// rtl/wb_retire_pkg.sv - shared types for the multi-slot retirement stage
// Contents: rob_entry_t (one reorder-buffer head entry) and retire_state_t.
package wb_retire_pkg;

    typedef struct packed {
        logic [4:0]  dest_reg;        // architectural destination register
        logic        dest_reg_valid;  // entry writes dest_reg
        logic [31:0] result_lo;       // register-file result / LO half
        logic [31:0] result_hi;       // HI half, meaningful when hilo_valid
        logic        hilo_valid;      // entry writes the HI/LO pair
        logic        is_store;        // entry commits through the store queue
        logic        exception;       // entry raised an exception
        logic [31:0] pc;              // instruction address
    } rob_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } retire_state_t;

endpackage

// File: rtl/wb_retire_select.sv
// rtl/wb_retire_select.sv - combinational selection of the retirable ROB head prefix
// Ports:
//   slot_data/slot_valid  ROB head entries, slot 0 oldest
//   empty                 ROB empty, masks every slot
//   run                   retire stage is in RUN (selection disabled otherwise)
//   store_commit_ready    store queue accepts the pending store
//   retire_mask           slots whose results commit this cycle
//   wr_mask               retire_mask filtered by dest validity, r0 and collapsing
//   head_exception        slot 0 is a valid excepting entry
//   consume_count         number of head slots popped
//   store_commit_valid    a store sits at the boundary of the retirable prefix
module wb_retire_select
    import wb_retire_pkg::*;
#(
    parameter int RETIRE_COUNT = 4,
    parameter int COUNT_WIDTH  = $clog2(RETIRE_COUNT + 1)
) (
    input  rob_entry_t                slot_data [RETIRE_COUNT],
    input  logic [RETIRE_COUNT-1:0]   slot_valid,
    input  logic                      empty,
    input  logic                      run,
    input  logic                      store_commit_ready,
    output logic [RETIRE_COUNT-1:0]   retire_mask,
    output logic [RETIRE_COUNT-1:0]   wr_mask,
    output logic                      head_exception,
    output logic [COUNT_WIDTH-1:0]    consume_count,
    output logic                      store_commit_valid
);

    logic open;
    logic store_seen;
    logic hilo_seen;
    logic unused_fields;

    always_comb begin
        retire_mask        = '0;
        consume_count      = '0;
        store_commit_valid = 1'b0;
        store_seen         = 1'b0;
        hilo_seen          = 1'b0;
        open               = run & ~empty;
        head_exception     = run & ~empty & slot_valid[0] & slot_data[0].exception;

        // Walk oldest to youngest; the first slot that cannot retire closes
        // the prefix for everything behind it.
        for (int i = 0; i < RETIRE_COUNT; i++) begin
            if (open && slot_valid[i] && !slot_data[i].exception) begin
                // Valid regardless of ready: the store queue needs to see it
                // before it can answer.
                if (slot_data[i].is_store && !store_seen) begin
                    store_commit_valid = 1'b1;
                end
                if ((slot_data[i].is_store && (store_seen || !store_commit_ready)) ||
                    (slot_data[i].hilo_valid && hilo_seen)) begin
                    open = 1'b0;
                end else begin
                    retire_mask[i] = 1'b1;
                    consume_count  = consume_count + 1'b1;
                    store_seen     = store_seen | slot_data[i].is_store;
                    hilo_seen      = hilo_seen | slot_data[i].hilo_valid;
                end
            end else begin
                open = 1'b0;
            end
        end

        // The excepting head is popped but commits nothing.
        if (head_exception) begin
            consume_count = COUNT_WIDTH'(1);
        end
    end

    // A retiring write survives only if no younger retiring slot targets the
    // same register; the youngest value is the architectural one.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < RETIRE_COUNT; i++) begin
            if (retire_mask[i] && slot_data[i].dest_reg_valid && slot_data[i].dest_reg != 5'd0) begin
                wr_mask[i] = 1'b1;
                for (int j = i + 1; j < RETIRE_COUNT; j++) begin
                    if (retire_mask[j] && slot_data[j].dest_reg_valid &&
                        slot_data[j].dest_reg == slot_data[i].dest_reg) begin
                        wr_mask[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Result payloads and PCs are consumed by the parent, not here.
    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < RETIRE_COUNT; i++) begin
            unused_fields = unused_fields ^ (^{slot_data[i].result_lo, slot_data[i].result_hi, slot_data[i].pc});
        end
    end

endmodule

// File: rtl/wb_retire.sv
// rtl/wb_retire.sv - in-order multi-slot retirement stage with precise exceptions
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   slot_data, slot_valid   ROB head entries (slot 0 oldest) and their valid flags
//   empty                   ROB empty
//   consume, consume_count  combinational pop request and pop count
//   store_commit_valid/ready  store queue handshake for the oldest pending store
//   rfile_wr_*              registered register-file write ports, one per slot
//   hilo_wr_*               registered HI/LO write port
//   flush, flush_pc         registered one-cycle flush pulse and redirect target
//   epc                     PC of the most recent excepting instruction
//   retired_count           running count of retired instructions
module wb_retire
    import wb_retire_pkg::*;
#(
    parameter int          RETIRE_COUNT = 4,
    parameter int          COUNT_WIDTH  = $clog2(RETIRE_COUNT + 1),
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic                     clock,
    input  logic                     reset,
    input  rob_entry_t               slot_data [RETIRE_COUNT],
    input  logic [RETIRE_COUNT-1:0]  slot_valid,
    input  logic                     empty,
    output logic                     consume,
    output logic [COUNT_WIDTH-1:0]   consume_count,
    output logic                     store_commit_valid,
    input  logic                     store_commit_ready,
    output logic [4:0]               rfile_wr_addr [RETIRE_COUNT],
    output logic [RETIRE_COUNT-1:0]  rfile_wr_enable,
    output logic [31:0]              rfile_wr_data [RETIRE_COUNT],
    output logic                     hilo_wr_enable,
    output logic [31:0]              hilo_wr_hi,
    output logic [31:0]              hilo_wr_lo,
    output logic                     flush,
    output logic [31:0]              flush_pc,
    output logic [31:0]              epc,
    output logic [31:0]              retired_count
);

    retire_state_t            state;
    retire_state_t            next_state;
    logic [RETIRE_COUNT-1:0]  retire_mask;
    logic [RETIRE_COUNT-1:0]  wr_mask;
    logic                     head_exception;
    logic                     hilo_sel;
    logic [31:0]              hilo_sel_hi;
    logic [31:0]              hilo_sel_lo;

    wb_retire_select #(
        .RETIRE_COUNT (RETIRE_COUNT),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_select (
        .slot_data          (slot_data),
        .slot_valid         (slot_valid),
        .empty              (empty),
        .run                (state == RUN),
        .store_commit_ready (store_commit_ready),
        .retire_mask        (retire_mask),
        .wr_mask            (wr_mask),
        .head_exception     (head_exception),
        .consume_count      (consume_count),
        .store_commit_valid (store_commit_valid)
    );

    assign consume = (consume_count != '0);

    // After an exception, wait for the ROB to empty so no wrong-path entry
    // can retire; the emptying cycle itself retires nothing.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (head_exception) next_state = DRAIN;
            DRAIN:   if (empty)          next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // At most one retiring slot carries HI/LO, so a priority pick is exact.
    always_comb begin
        hilo_sel    = 1'b0;
        hilo_sel_hi = '0;
        hilo_sel_lo = '0;
        for (int i = RETIRE_COUNT - 1; i >= 0; i--) begin
            if (retire_mask[i] && slot_data[i].hilo_valid) begin
                hilo_sel    = 1'b1;
                hilo_sel_hi = slot_data[i].result_hi;
                hilo_sel_lo = slot_data[i].result_lo;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rfile_wr_enable <= '0;
            for (int i = 0; i < RETIRE_COUNT; i++) begin
                rfile_wr_addr[i] <= '0;
                rfile_wr_data[i] <= '0;
            end
            hilo_wr_enable <= 1'b0;
            hilo_wr_hi     <= '0;
            hilo_wr_lo     <= '0;
            flush          <= 1'b0;
            flush_pc       <= '0;
            epc            <= '0;
            retired_count  <= '0;
        end else begin
            rfile_wr_enable <= wr_mask;
            for (int i = 0; i < RETIRE_COUNT; i++) begin
                rfile_wr_addr[i] <= wr_mask[i] ? slot_data[i].dest_reg  : 5'd0;
                rfile_wr_data[i] <= wr_mask[i] ? slot_data[i].result_lo : 32'd0;
            end
            hilo_wr_enable <= hilo_sel;
            hilo_wr_hi     <= hilo_sel_hi;
            hilo_wr_lo     <= hilo_sel_lo;
            flush          <= head_exception;
            flush_pc       <= head_exception ? EXC_VECTOR : 32'd0;
            if (head_exception) begin
                epc <= slot_data[0].pc;
            end
            // The popped excepting entry does not count as retired.
            if (!head_exception) begin
                retired_count <= retired_count + 32'(consume_count);
            end
        end
    end

endmodule

// File: tb/tb_wb_retire.sv
// tb/tb_wb_retire.sv - scoreboard testbench for wb_retire
module tb_wb_retire;
    import wb_retire_pkg::*;

    localparam int          N   = 4;
    localparam logic [31:0] EXC = 32'hBFC0_0380;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    rob_entry_t  slot_data [N];
    logic [N-1:0] slot_valid;
    logic        empty;
    logic        store_commit_ready;
    logic        consume;
    logic [2:0]  consume_count;
    logic        store_commit_valid;
    logic [4:0]  rfile_wr_addr [N];
    logic [N-1:0] rfile_wr_enable;
    logic [31:0] rfile_wr_data [N];
    logic        hilo_wr_enable;
    logic [31:0] hilo_wr_hi;
    logic [31:0] hilo_wr_lo;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] epc;
    logic [31:0] retired_count;

    wb_retire dut (
        .clock              (clock),
        .reset              (reset),
        .slot_data          (slot_data),
        .slot_valid         (slot_valid),
        .empty              (empty),
        .consume            (consume),
        .consume_count      (consume_count),
        .store_commit_valid (store_commit_valid),
        .store_commit_ready (store_commit_ready),
        .rfile_wr_addr      (rfile_wr_addr),
        .rfile_wr_enable    (rfile_wr_enable),
        .rfile_wr_data      (rfile_wr_data),
        .hilo_wr_enable     (hilo_wr_enable),
        .hilo_wr_hi         (hilo_wr_hi),
        .hilo_wr_lo         (hilo_wr_lo),
        .flush              (flush),
        .flush_pc           (flush_pc),
        .epc                (epc),
        .retired_count      (retired_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cnt;
        logic        scv;
        logic [31:0] rc;
    } cexp_t;

    typedef struct {
        logic [3:0]        en;
        logic [3:0][4:0]   addr;
        logic [3:0][31:0]  data;
        logic              hen;
        logic [31:0]       hi;
        logic [31:0]       lo;
        logic              fl;
        logic [31:0]       epc;
    } wexp_t;

    cexp_t cq[$];
    wexp_t wq[$];
    cexp_t mc;
    wexp_t mw;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  live  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic rob_entry_t pl(input logic [4:0] d, input logic [31:0] lo);
        rob_entry_t e = '0;
        e.dest_reg       = d;
        e.dest_reg_valid = 1'b1;
        e.result_lo      = lo;
        e.pc             = 32'h0040_0000 | lo;
        return e;
    endfunction

    function automatic rob_entry_t st();
        rob_entry_t e = '0;
        e.is_store = 1'b1;
        e.pc       = 32'h0040_0ff0;
        return e;
    endfunction

    function automatic rob_entry_t hl(input logic [31:0] hi, input logic [31:0] lo);
        rob_entry_t e = '0;
        e.hilo_valid = 1'b1;
        e.result_hi  = hi;
        e.result_lo  = lo;
        return e;
    endfunction

    function automatic rob_entry_t ex(input logic [31:0] pc);
        rob_entry_t e = '0;
        e.exception      = 1'b1;
        e.dest_reg       = 5'd3;
        e.dest_reg_valid = 1'b1;
        e.result_lo      = 32'hDEAD_0000;
        e.pc             = pc;
        return e;
    endfunction

    task automatic exp_wr(input logic [3:0] en, input logic [3:0][4:0] addr,
                          input logic [3:0][31:0] data, input logic hen,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic fl, input logic [31:0] e_pc);
        wexp_t w;
        w.en = en; w.addr = addr; w.data = data; w.hen = hen;
        w.hi = hi; w.lo = lo; w.fl = fl; w.epc = e_pc;
        wq.push_back(w);
    endtask

    // Drive one cycle of head state (called at posedge+1) and queue the
    // expected combinational response for the monitor.
    task automatic step(input rob_entry_t s0, input rob_entry_t s1,
                        input rob_entry_t s2, input rob_entry_t s3,
                        input logic [3:0] v, input logic e, input logic rdy,
                        input int cnt, input logic scv, input logic [31:0] rc);
        cexp_t c;
        slot_data[0] = s0; slot_data[1] = s1; slot_data[2] = s2; slot_data[3] = s3;
        slot_valid = v; empty = e; store_commit_ready = rdy;
        c.cnt = cnt; c.scv = scv; c.rc = rc;
        cq.push_back(c);
        live = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    // Monitor: combinational outputs every live cycle, registered writes
    // whenever the DUT presents any of them.
    always @(negedge clock) begin
        if (live) begin
            if (cq.size() == 0) begin
                chk("comb_queue_underflow", 32'd1, 32'd0);
            end else begin
                mc = cq.pop_front();
                chk("consume_count", 32'(consume_count), mc.cnt);
                chk("consume", 32'(consume), 32'(mc.cnt != 0));
                chk("store_commit_valid", 32'(store_commit_valid), 32'(mc.scv));
                chk("retired_count", retired_count, mc.rc);
            end
        end
        if ((|rfile_wr_enable) || hilo_wr_enable || flush) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mw = wq.pop_front();
                chk("rf_enable", 32'(rfile_wr_enable), 32'(mw.en));
                for (int i = 0; i < N; i++) begin
                    if (mw.en[i]) begin
                        chk($sformatf("rf_addr[%0d]", i), 32'(rfile_wr_addr[i]), 32'(mw.addr[i]));
                        chk($sformatf("rf_data[%0d]", i), rfile_wr_data[i], mw.data[i]);
                    end
                end
                chk("hilo_enable", 32'(hilo_wr_enable), 32'(mw.hen));
                if (mw.hen) begin
                    chk("hilo_hi", hilo_wr_hi, mw.hi);
                    chk("hilo_lo", hilo_wr_lo, mw.lo);
                end
                chk("flush", 32'(flush), 32'(mw.fl));
                chk("flush_pc", flush_pc, mw.fl ? EXC : 32'd0);
                chk("epc", epc, mw.epc);
            end
        end
    end

    rob_entry_t z;

    initial begin
        z = '0;
        for (int i = 0; i < N; i++) slot_data[i] = '0;
        slot_valid = '0; empty = 1'b1; store_commit_ready = 1'b0;

        @(negedge clock);
        chk("reset_consume_count", 32'(consume_count), 32'd0);
        chk("reset_rf_enable", 32'(rfile_wr_enable), 32'd0);
        chk("reset_hilo_enable", 32'(hilo_wr_enable), 32'd0);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_epc", epc, 32'd0);
        chk("reset_retired_count", retired_count, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // idle
        step(z, z, z, z, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 32'd0);
        // four independent writes
        exp_wr(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(pl(1, 32'h11), pl(2, 32'h22), pl(3, 32'h33), pl(4, 32'h44),
             4'b1111, 1'b0, 1'b0, 4, 1'b0, 32'd0);
        // same-destination collapse, r0 suppressed, slot 3 invalid
        exp_wr(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {32'h0, 32'hCCCC_0003, 32'h0, 32'h0},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(pl(5, 32'hAAAA_0001), pl(0, 32'h5555), pl(5, 32'hCCCC_0003), pl(9, 32'h99),
             4'b0111, 1'b0, 1'b0, 3, 1'b0, 32'd4);
        // store in slot 1 not ready
        exp_wr(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h0, 32'h70},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(pl(7, 32'h70), st(), pl(8, 32'h80), pl(9, 32'h90),
             4'b1111, 1'b0, 1'b0, 1, 1'b1, 32'd7);
        // store now at head and ready
        exp_wr(4'b1110, {5'd10, 5'd9, 5'd8, 5'd0}, {32'hA0, 32'h90, 32'h80, 32'h0},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(st(), pl(8, 32'h80), pl(9, 32'h90), pl(10, 32'hA0),
             4'b1111, 1'b0, 1'b1, 4, 1'b1, 32'd8);
        // second store stops the prefix
        exp_wr(4'b0001, {5'd0, 5'd0, 5'd0, 5'd11}, {32'h0, 32'h0, 32'h0, 32'hB0},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(pl(11, 32'hB0), st(), st(), pl(12, 32'hC0),
             4'b1111, 1'b0, 1'b1, 2, 1'b1, 32'd12);
        // two HI/LO writers
        exp_wr(4'b0000, '0, '0, 1'b1, 32'h1000, 32'h2000, 1'b0, 32'd0);
        step(hl(32'h1000, 32'h2000), hl(32'h3000, 32'h4000), pl(13, 32'hD0), pl(14, 32'hE0),
             4'b1111, 1'b0, 1'b0, 1, 1'b0, 32'd14);
        exp_wr(4'b0110, {5'd0, 5'd14, 5'd13, 5'd0}, {32'h0, 32'hE0, 32'hD0, 32'h0},
               1'b1, 32'h3000, 32'h4000, 1'b0, 32'd0);
        step(hl(32'h3000, 32'h4000), pl(13, 32'hD0), pl(14, 32'hE0), z,
             4'b0111, 1'b0, 1'b0, 3, 1'b0, 32'd15);
        // exception at slot 2 truncates only
        exp_wr(4'b0011, {5'd0, 5'd0, 5'd16, 5'd15}, {32'h0, 32'h0, 32'h100, 32'hF0},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(pl(15, 32'hF0), pl(16, 32'h100), ex(32'h0040_0300), pl(17, 32'h110),
             4'b1111, 1'b0, 1'b0, 2, 1'b0, 32'd18);
        // exception at head beats a ready store
        exp_wr(4'b0000, '0, '0, 1'b0, 0, 0, 1'b1, 32'h0040_0100);
        step(ex(32'h0040_0100), st(), pl(1, 32'h1), pl(2, 32'h2),
             4'b1111, 1'b0, 1'b1, 1, 1'b0, 32'd20);
        // DRAIN: nothing retires, then empty returns to RUN without retiring
        step(st(), pl(1, 32'h1), pl(2, 32'h2), pl(3, 32'h3),
             4'b1111, 1'b0, 1'b1, 0, 1'b0, 32'd20);
        step(st(), pl(1, 32'h1), pl(2, 32'h2), pl(3, 32'h3),
             4'b1111, 1'b1, 1'b1, 0, 1'b0, 32'd20);
        // back in RUN, epc held
        exp_wr(4'b0001, {5'd0, 5'd0, 5'd0, 5'd18}, {32'h0, 32'h0, 32'h0, 32'h120},
               1'b0, 0, 0, 1'b0, 32'h0040_0100);
        step(pl(18, 32'h120), z, z, z, 4'b0001, 1'b0, 1'b0, 1, 1'b0, 32'd20);
        // empty masks valid slots
        step(pl(1, 32'h1), pl(2, 32'h2), pl(3, 32'h3), pl(4, 32'h4),
             4'b1111, 1'b1, 1'b0, 0, 1'b0, 32'd21);
        // second exception, then reset during the flush cycle
        exp_wr(4'b0000, '0, '0, 1'b0, 0, 0, 1'b1, 32'h0040_0200);
        step(ex(32'h0040_0200), pl(1, 32'h1), pl(2, 32'h2), pl(3, 32'h3),
             4'b1111, 1'b0, 1'b0, 1, 1'b0, 32'd21);
        live = 1'b0;
        slot_data[0] = pl(1, 32'h11); slot_data[1] = pl(2, 32'h22);
        slot_data[2] = pl(3, 32'h33); slot_data[3] = pl(4, 32'h44);
        slot_valid = 4'b1111; empty = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_retired_count", retired_count, 32'd0);
        chk("rst_rf_enable", 32'(rfile_wr_enable), 32'd0);
        chk("rst_run_consume_count", 32'(consume_count), 32'd4);
        @(posedge clock);
        #1 reset = 1'b0;
        exp_wr(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11},
               1'b0, 0, 0, 1'b0, 32'd0);
        step(pl(1, 32'h11), pl(2, 32'h22), pl(3, 32'h33), pl(4, 32'h44),
             4'b1111, 1'b0, 1'b0, 4, 1'b0, 32'd0);
        step(z, z, z, z, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 32'd4);
        live = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("comb_queue_drained", cq.size(), 32'd0);
        chk("write_queue_drained", wq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
